// File: rtl/mvm_pkg.sv
// Shared types and arithmetic helpers for the double-buffered streaming matrix-vector engine.
// Output reduction mode is chosen in axis_mvm_dbuf by the MVM_OUT_SAT_EN macro.
package mvm_pkg;

    typedef enum logic [1:0] {
        S_EMPTY    = 2'd0,
        S_RUN      = 2'd1,
        S_RUN_LOAD = 2'd2
    } load_state_t;

    function automatic int acc_width(input int dw, input int ww, input int cols);
        return dw + ww + $clog2(cols);
    endfunction

    // Low out_w bits of the result are the reduced element (clamped or wrapped).
    function automatic logic signed [63:0] reduce_acc(input logic signed [63:0] acc,
                                                      input int out_w,
                                                      input int acc_w,
                                                      input bit sat_en);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (sat_en && (out_w < acc_w)) begin
            if (acc > hi) return hi;
            if (acc < lo) return lo;
        end
        return acc;
    endfunction

endpackage

// File: rtl/mvm_out_fifo.sv
// Synchronous result FIFO; count is exported so the producer can reserve space before issuing work.
module mvm_out_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage arrays carry no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/axis_mvm_dbuf.sv
// Streaming y = W*x engine with a shadow weight bank reloadable mid-stream and a credit-guarded output FIFO.
// Define MVM_OUT_SAT_EN to saturate each output element; otherwise outputs wrap.
module axis_mvm_dbuf
    import mvm_pkg::*;
#(
    parameter int ROWS         = 16,
    parameter int COLS         = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int OUT_WIDTH    = 16,
    parameter int DEPTH        = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [COLS*DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                          s_axis_tuser,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [ROWS*OUT_WIDTH-1:0]     m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          weights_valid,
    output logic                          active_bank,
    output logic                          nocfg_err
);
    localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, WEIGHT_WIDTH, COLS);
    localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNT_W      = $clog2(DEPTH) + 1;
`ifdef MVM_OUT_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    load_state_t       state, state_n;
    logic [ROW_W-1:0]  row_cnt, row_cnt_n;
    logic              bank_n, wv_n, err_n;
    logic              accept, w_accept, d_accept, d_compute;
    logic              s1_valid;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used;
    logic              fifo_empty;

    logic signed [WEIGHT_WIDTH-1:0] wbank   [2][ROWS][COLS];
    logic signed [PROD_WIDTH-1:0]   prod    [ROWS][COLS];
    logic signed [ACC_WIDTH-1:0]    row_sum [ROWS];
    logic [ROWS*OUT_WIDTH-1:0]      red_vec;

    // Space is reserved for a result as soon as its beat is accepted, so nothing is ever dropped.
    assign credit_used   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid};
    assign s_axis_tready = rstn && (credit_used < (CNT_W+1)'(DEPTH));
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign w_accept      = accept & s_axis_tuser;
    assign d_accept      = accept & ~s_axis_tuser;
    assign d_compute     = d_accept & (state != S_EMPTY);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_n   = state;
        row_cnt_n = row_cnt;
        bank_n    = active_bank;
        wv_n      = weights_valid;
        err_n     = nocfg_err;
        if (w_accept) begin
            if (row_cnt == ROW_W'(ROWS - 1)) begin
                row_cnt_n = '0;
                bank_n    = ~active_bank;
                wv_n      = 1'b1;
                state_n   = S_RUN;
            end else begin
                row_cnt_n = row_cnt + ROW_W'(1);
                state_n   = (state == S_EMPTY) ? S_EMPTY : S_RUN_LOAD;
            end
        end
        if (d_accept && (state == S_EMPTY)) err_n = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_EMPTY;
            row_cnt       <= '0;
            active_bank   <= 1'b0;
            weights_valid <= 1'b0;
            nocfg_err     <= 1'b0;
            s1_valid      <= 1'b0;
        end else begin
            state         <= state_n;
            row_cnt       <= row_cnt_n;
            active_bank   <= bank_n;
            weights_valid <= wv_n;
            nocfg_err     <= err_n;
            s1_valid      <= d_compute;
        end
    end

    // Weight beats always target the shadow bank; the active bank stays frozen until commit.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int c = 0; c < COLS; c++)
                wbank[~active_bank][row_cnt][c] <= s_axis_tdata[c*DATA_WIDTH +: WEIGHT_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (d_compute) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    prod[r][c] <= PROD_WIDTH'($signed(s_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH]))
                                * PROD_WIDTH'(wbank[active_bank][r][c]);
        end
    end

    always_comb begin
        red_vec = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_sum[r] = '0;
            for (int c = 0; c < COLS; c++)
                row_sum[r] = row_sum[r] + ACC_WIDTH'(prod[r][c]);
            red_vec[r*OUT_WIDTH +: OUT_WIDTH] =
                OUT_WIDTH'(reduce_acc(64'(row_sum[r]), OUT_WIDTH, ACC_WIDTH, SAT_EN));
        end
    end

    mvm_out_fifo #(
        .WIDTH (ROWS*OUT_WIDTH),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (s1_valid),
        .push_data (red_vec),
        .pop       (m_axis_tready),
        .pop_data  (m_axis_tdata),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign m_axis_tvalid = ~fifo_empty;

endmodule

// File: tb/tb_axis_mvm_dbuf.sv
// Scoreboard bench for axis_mvm_dbuf: a plain-arithmetic matrix model predicts every output vector.
module tb_axis_mvm_dbuf;
    localparam int ROWS  = 16;
    localparam int COLS  = 16;
    localparam int DW    = 8;
    localparam int WW    = 8;
    localparam int OW    = 16;
    localparam int DEPTH = 4;
    localparam int XW    = COLS*DW;
    localparam int YW    = ROWS*OW;

    logic          clk = 1'b0;
    logic          rstn;
    logic [XW-1:0] s_axis_tdata;
    logic          s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [YW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          weights_valid;
    logic          active_bank;
    logic          nocfg_err;

    always #5 clk = ~clk;

    axis_mvm_dbuf #(
        .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .OUT_WIDTH(OW), .DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .weights_valid (weights_valid),
        .active_bank   (active_bank),
        .nocfg_err     (nocfg_err)
    );

    int            total = 0;
    int            bad   = 0;
    int            stalls = 0;
    bit            rand_ready = 1'b0;
    logic [YW-1:0] exp_q [$];

    // Reference model: two weight matrices, which one is live, and the next shadow row.
    int wm [2][ROWS][COLS];
    int m_bank;
    int m_row;
    bit m_loaded;

    task automatic check(input string name, input logic [YW-1:0] act, input logic [YW-1:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    function automatic logic [XW-1:0] fill_x(input int v);
        logic [XW-1:0] x;
        for (int c = 0; c < COLS; c++) x[c*DW +: DW] = DW'(v);
        return x;
    endfunction

    function automatic logic [XW-1:0] rand_x();
        logic [XW-1:0] x;
        for (int c = 0; c < COLS; c++) x[c*DW +: DW] = DW'($urandom);
        return x;
    endfunction

    function automatic logic [YW-1:0] model_y(input logic [XW-1:0] x);
        logic [YW-1:0] y;
        y = '0;
        for (int r = 0; r < ROWS; r++) begin
            longint acc;
            longint hi;
            logic [63:0] t;
            logic signed [DW-1:0] e;
            acc = 0;
            for (int c = 0; c < COLS; c++) begin
                e = x[c*DW +: DW];
                acc += longint'(e) * longint'(wm[m_bank][r][c]);
            end
            hi = (longint'(1) << (OW - 1)) - 1;
`ifdef MVM_OUT_SAT_EN
            if (acc > hi) acc = hi;
            if (acc < -hi - 1) acc = -hi - 1;
`endif
            t = acc;
            y[r*OW +: OW] = t[OW-1:0];
        end
        return y;
    endfunction

    task automatic model_accept(input bit user, input logic [XW-1:0] d);
        logic signed [WW-1:0] w;
        if (user) begin
            for (int c = 0; c < COLS; c++) begin
                w = d[c*DW +: WW];
                wm[1 - m_bank][m_row][c] = int'(w);
            end
            if (m_row == ROWS - 1) begin
                m_bank   = 1 - m_bank;
                m_row    = 0;
                m_loaded = 1'b1;
            end else begin
                m_row++;
            end
        end else if (m_loaded) begin
            exp_q.push_back(model_y(d));
        end
    endtask

    // Called and returns at posedge+1; the beat is accepted on the posedge in between.
    task automatic send(input bit user, input logic [XW-1:0] d);
        int waited;
        waited        = 0;
        s_axis_tuser  = user;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!s_axis_tready) begin
            waited++;
            if (waited > 200) begin
                check("send_timeout", YW'(s_axis_tready), YW'(1));
                s_axis_tvalid = 1'b0;
                @(posedge clk); #1;
                return;
            end
            @(negedge clk);
        end
        if (waited > 0) stalls++;
        model_accept(user, d);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check("rst_s_tready",  YW'(s_axis_tready), YW'(0));
        check("rst_m_tvalid",  YW'(m_axis_tvalid), YW'(0));
        check("rst_m_tdata",   m_axis_tdata,       YW'(0));
        check("rst_wvalid",    YW'(weights_valid), YW'(0));
        check("rst_bank",      YW'(active_bank),   YW'(0));
        check("rst_nocfg",     YW'(nocfg_err),     YW'(0));
        exp_q.delete();
        m_bank   = 0;
        m_row    = 0;
        m_loaded = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic load_const(input int v);
        for (int r = 0; r < ROWS; r++) send(1'b1, fill_x(v));
    endtask

    task automatic load_identity();
        logic [XW-1:0] row;
        for (int r = 0; r < ROWS; r++) begin
            row = '0;
            row[r*DW +: DW] = DW'(1);
            send(1'b1, row);
            if (r == ROWS - 2) check("wvalid_before_last_row", YW'(weights_valid), YW'(0));
            if (r == ROWS - 1) check("wvalid_after_last_row",  YW'(weights_valid), YW'(1));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        m_axis_tready = 1'b1;
        while (exp_q.size() > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_queue_empty", YW'(exp_q.size()), YW'(0));
        check("drain_tvalid_low",  YW'(m_axis_tvalid), YW'(0));
    endtask

    always @(negedge clk) begin
        if (rstn && m_axis_tvalid && m_axis_tready) begin
            logic [YW-1:0] e;
            if (exp_q.size() == 0) begin
                check("spurious_out", YW'(m_axis_tvalid), YW'(0));
            end else begin
                e = exp_q.pop_front();
                check("y_out", m_axis_tdata, e);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            m_axis_tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [XW-1:0] x;
        rstn          = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        m_bank        = 0;
        m_row         = 0;
        m_loaded      = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Data before any weights: swallowed, error flag set, nothing emitted.
        send(1'b0, fill_x(5));
        repeat (3) @(posedge clk);
        #1;
        check("nocfg_set",        YW'(nocfg_err),     YW'(1));
        check("nocfg_no_output",  YW'(m_axis_tvalid), YW'(0));

        // Identity weights, x[c] = c, with a two-cycle latency check.
        load_identity();
        check("bank_after_commit", YW'(active_bank), YW'(1));
        for (int c = 0; c < COLS; c++) x[c*DW +: DW] = DW'(c);
        send(1'b0, x);
        check("latency_not_early", YW'(m_axis_tvalid), YW'(0));
        @(posedge clk); #1;
        check("latency_two",       YW'(m_axis_tvalid), YW'(1));
        check("nocfg_sticky",      YW'(nocfg_err),     YW'(1));
        drain();

        // Mid-stream reload of W=3 while streaming x=1 under W=2: no stall allowed.
        do_reset();
        load_const(2);
        stalls = 0;
        for (int i = 0; i < 4; i++) send(1'b0, fill_x(1));
        for (int r = 0; r < ROWS; r++) begin
            send(1'b1, fill_x(3));
            send(1'b0, fill_x(1));
        end
        for (int i = 0; i < 4; i++) send(1'b0, fill_x(1));
        check("reload_no_stall", YW'(stalls), YW'(0));
        drain();

        // Backpressure: exactly DEPTH results held, input stalls, then all delivered in order.
        m_axis_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send(1'b0, rand_x());
            if (i == DEPTH - 2) check("credit_not_full", YW'(s_axis_tready), YW'(1));
            if (i == DEPTH - 1) check("credit_full",     YW'(s_axis_tready), YW'(0));
        end
        repeat (5) @(posedge clk);
        #1;
        check("credit_full_hold", YW'(s_axis_tready), YW'(0));
        check("full_tvalid",      YW'(m_axis_tvalid), YW'(1));
        drain();

        // Extreme values: reduction (saturate or wrap) at both ends.
        load_const(127);
        send(1'b0, fill_x(127));
        send(1'b0, fill_x(-128));
        load_const(-128);
        send(1'b0, fill_x(-128));
        drain();

        // Random mix of weight and data beats with random output backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) send(($urandom_range(0, 3) == 0), rand_x());
        rand_ready = 1'b0;
        @(posedge clk); #1;
        drain();

        // Reset with a full FIFO, then mid-load at row 7; next load must restart at row 0.
        m_axis_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(1'b0, rand_x());
        do_reset();
        m_axis_tready = 1'b1;
        for (int r = 0; r < 7; r++) send(1'b1, fill_x(5));
        do_reset();
        load_identity();
        for (int i = 0; i < 6; i++) send(1'b0, rand_x());
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_mvm_dbuf.md
# axis_mvm_dbuf

Second-generation streaming matrix-vector engine: computes y = W·x for a ROWS×COLS signed weight matrix on every accepted data beat. Unlike the single-shot loader it succeeds, weights are reloadable at any time into a shadow bank, without stalling or draining the data stream. Sits between the input AXI-Stream unpacking stage and the downstream accumulator/DMA, with a credit-guarded output FIFO so computed results are never dropped.

## Interface
- ROWS, 16, output vector length / weight rows
- COLS, 16, input vector length / weight columns
- DATA_WIDTH, 8, signed input element width
- WEIGHT_WIDTH, 8, signed weight width; must be ≤ DATA_WIDTH
- OUT_WIDTH, 16, output element width
- DEPTH, 4, output FIFO depth; power of 2, ≥ 2
- clk  in  1  clock; one clock domain, all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- s_axis_tdata  in  COLS*DATA_WIDTH  element c at [c*DATA_WIDTH +: DATA_WIDTH]; weight beats use [c*DATA_WIDTH +: WEIGHT_WIDTH]
- s_axis_tuser  in  1  1 = weight row beat, 0 = data beat
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  ROWS*OUT_WIDTH  y[r] at [r*OUT_WIDTH +: OUT_WIDTH]
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- weights_valid  out  1  at least one full matrix committed
- active_bank  out  1  bank used by newly accepted data beats
- nocfg_err  out  1  sticky: data beat accepted while weights_valid = 0

## Operation
- Two weight banks. Weight beats fill the shadow bank (!active_bank), row by row, row counter 0..ROWS-1.
- Loader FSM: S_EMPTY (no weights), S_RUN (active bank valid, row_cnt = 0), S_RUN_LOAD (shadow partially written). S_EMPTY loads into shadow as well.
- Accepting the weight beat with row_cnt = ROWS-1: commit — toggle active_bank, weights_valid ← 1, row_cnt ← 0, go S_RUN. Otherwise row_cnt++ and go/stay S_RUN_LOAD (or S_EMPTY).
- Data beat accepted in S_RUN/S_RUN_LOAD: computed with the active bank at the acceptance edge; partial shadow loads never affect it.
- Data beat accepted in S_EMPTY: consumed, discarded, nocfg_err ← 1; no output produced.
- Arithmetic: signed products, full-precision accumulation in ACC_WIDTH = DATA_WIDTH + WEIGHT_WIDTH + clog2(COLS). Reduction to OUT_WIDTH per Configuration.
- Credit: inflight = results in pipeline not yet in FIFO. s_axis_tready = (fifo_count + inflight < DEPTH), identical for weight and data beats.

## Timing
- Reset: s_axis_tready 0 while rstn low, m_axis_tvalid 0, m_axis_tdata 0, weights_valid 0, active_bank 0, nocfg_err 0, FSM S_EMPTY, row_cnt 0, FIFO empty. Bank contents not cleared.
- Reset asserted mid-load or mid-pipeline: all in-flight results and FIFO contents discarded; partial load abandoned.
- Pipeline: stage 1 registers the ROWS×COLS products at the acceptance edge k; stage 2 registers reduced sums into the FIFO at edge k+1; m_axis_tvalid high after edge k+1 when FIFO was empty (latency 2).
- Full throughput: one beat per cycle while m_axis_tready = 1.
- m_axis_tdata stable while m_axis_tvalid & !m_axis_tready.
- FIFO push and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
- Commit and the next data beat: data beat on the cycle after the commit uses the new bank; beats already accepted keep the old bank.

## Configuration
- MVM_OUT_SAT_EN defined: each y[r] clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Undefined: y[r] = low OUT_WIDTH bits of the accumulator (two's-complement wrap).
- Ignored when OUT_WIDTH ≥ ACC_WIDTH (sign-extend).

## Structure
- Package mvm_pkg: loader state enum (S_EMPTY, S_RUN, S_RUN_LOAD), acc_width(DATA_WIDTH, WEIGHT_WIDTH, COLS) constant function, sat/wrap reduction function.
- Sub-module mvm_out_fifo: synchronous FIFO, DEPTH entries of ROWS*OUT_WIDTH, exposes count for credit logic.

## Test plan
- Reset, then 16 weight rows of identity (W[r][r]=1) and data x[c]=c -> y[r]=r, first result two cycles after the data beat, weights_valid=1 after row 15.
- Data beat before any weights -> no output, nocfg_err=1, stays 1 until reset.
- Running stream with x=all 1, W all 2; reload W all 3 mid-stream -> outputs 32 until commit edge, 48 for beats after it, no gap and no stall.
- m_axis_tready held low -> exactly DEPTH results stored, s_axis_tready drops; release -> all delivered in order, none lost.
- x all 127, W all 127, OUT_WIDTH=16 -> with MVM_OUT_SAT_EN 32767; without, 258064 mod 2^16 = 61456 (as signed, -4080).
- rstn pulsed low mid-load (row 7) and with FIFO full -> m_axis_tvalid=0, weights_valid=0, next load starts at row 0.
